// File: rtl/sensor_pkg.sv
// Shared sensor-bus types and constants for the conditioner and downstream detector.
// Pure declarations; no logic, no latency, no backpressure.
package sensor_pkg;
  localparam int N_SENSORS               = 4;
  localparam int SENSOR_DEBOUNCE_DEFAULT = 4;

  typedef logic [N_SENSORS-1:0] sensor_vec_t;
endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-bus bundle: raw lines in, debounced vector and change strobe out.
// Wires only; no latency, no backpressure (outputs are level/strobe, never stalled).
interface sensor_conditioner_if;
  import sensor_pkg::*;

  sensor_vec_t raw_sensors;
  sensor_vec_t sensors;
  logic        sensors_changed;

  modport master (output raw_sensors, input  sensors, input  sensors_changed);
  modport slave  (input  raw_sensors, output sensors, output sensors_changed);
endinterface

// File: rtl/sensor_debounce_bit.sv
// One sensor line: 2-flop synchronizer, stability counter and accepted-level flop.
// Latency DEBOUNCE_CYCLES+2 edges from raw to stable_out; no backpressure.
module sensor_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw_in,
  output logic stable_out,
  output logic accept_pulse
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // A differing level is the only way to reach CNT_MAX, so this is "accept with change".
  assign accept_pulse = (sync2 != stable_out) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      stable_out <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      if (sync2 == stable_out) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable_out <= sync2;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the four raw sensor lines into a clean registered vector plus a change strobe.
// Latency DEBOUNCE_CYCLES+2 edges; strobe coincides with the new vector; no backpressure.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SENSOR_DEBOUNCE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sensor_conditioner_if.slave  bus
);
  sensor_vec_t stable;
  sensor_vec_t accept;
  logic        changed;

  for (genvar i = 0; i < N_SENSORS; i++) begin : gen_bit
    sensor_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk          (clk),
      .n_rst        (n_rst),
      .raw_in       (bus.raw_sensors[i]),
      .stable_out   (stable[i]),
      .accept_pulse (accept[i])
    );
  end

  // Accepts on several bits at the same edge collapse into one strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

  assign bus.sensors         = stable;
  assign bus.sensors_changed = changed;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner at DEBOUNCE_CYCLES=4 (dut_a) and 2 (dut_b).
module tb_sensor_conditioner;
  import sensor_pkg::*;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  sensor_conditioner_if bus_a ();
  sensor_conditioner_if bus_b ();

  sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_a)
  );

  sensor_conditioner #(.DEBOUNCE_CYCLES(2)) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] s, input logic c);
    check({tag, ".sensors"}, 32'(bus_a.sensors), 32'(s));
    check({tag, ".changed"}, 32'(bus_a.sensors_changed), 32'(c));
  endtask

  task automatic check_b(input string tag, input logic [3:0] s, input logic c);
    check({tag, ".sensors"}, 32'(bus_b.sensors), 32'(s));
    check({tag, ".changed"}, 32'(bus_b.sensors_changed), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    n_rst    = 1'b0;
    bus_a.raw_sensors = 4'b1111;
    bus_b.raw_sensors = 4'b1111;

    // Held in reset with all raw lines high.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_a("rst_hold_a", 4'b0000, 1'b0);
      check_b("rst_hold_b", 4'b0000, 1'b0);
    end
    bus_a.raw_sensors = 4'b0000;
    bus_b.raw_sensors = 4'b0000;
    n_rst = 1'b1;
    step(8);
    check_a("idle_a", 4'b0000, 1'b0);

    // DEBOUNCE_CYCLES=2: a 1-edge glitch is rejected.
    bus_b.raw_sensors = 4'b0001;
    step(1);
    bus_b.raw_sensors = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_b("p2_glitch", 4'b0000, 1'b0);
    end
    // DEBOUNCE_CYCLES=2: a step lands after 4 edges.
    bus_b.raw_sensors = 4'b0001;
    step(3);
    check_b("p2_step_early", 4'b0000, 1'b0);
    step(1);
    check_b("p2_step", 4'b0001, 1'b1);
    step(1);
    check_b("p2_step_after", 4'b0001, 1'b0);

    // Clean step 0000 -> 0101 at the default depth.
    bus_a.raw_sensors = 4'b0101;
    step(5);
    check_a("step_early", 4'b0000, 1'b0);
    step(1);
    check_a("step_edge6", 4'b0101, 1'b1);
    step(1);
    check_a("step_after", 4'b0101, 1'b0);
    bus_a.raw_sensors = 4'b0000;
    step(6);
    check_a("fall_edge6", 4'b0000, 1'b1);
    step(1);
    check_a("fall_after", 4'b0000, 1'b0);

    // Bit 1 high for 3 edges: too short.
    bus_a.raw_sensors = 4'b0010;
    step(3);
    bus_a.raw_sensors = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_a("glitch3", 4'b0000, 1'b0);
    end

    // Bit 1 high for 4 edges: accepted, then released with a second strobe.
    bus_a.raw_sensors = 4'b0010;
    step(4);
    bus_a.raw_sensors = 4'b0000;
    step(1);
    check_a("pulse4_early", 4'b0000, 1'b0);
    step(1);
    check_a("pulse4_accept", 4'b0010, 1'b1);
    step(3);
    check_a("pulse4_held", 4'b0010, 1'b0);
    step(1);
    check_a("pulse4_release", 4'b0000, 1'b1);
    step(1);
    check_a("pulse4_after", 4'b0000, 1'b0);

    // Bits 0 and 3 together, bit 2 one edge later.
    bus_a.raw_sensors = 4'b1001;
    step(1);
    bus_a.raw_sensors = 4'b1101;
    step(4);
    check_a("stag_early", 4'b0000, 1'b0);
    step(1);
    check_a("stag_first", 4'b1001, 1'b1);
    step(1);
    check_a("stag_second", 4'b1101, 1'b1);
    step(1);
    check_a("stag_after", 4'b1101, 1'b0);

    // Asynchronous reset between edges clears outputs at once.
    #3;
    n_rst = 1'b0;
    #1;
    check_a("async_rst", 4'b0000, 1'b0);
    bus_a.raw_sensors = 4'b0000;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(6);
    check_a("post_rst_idle", 4'b0000, 1'b0);

    // Reset during a pending count restarts qualification.
    bus_a.raw_sensors = 4'b0001;
    step(3);
    n_rst = 1'b0;
    #2;
    check_a("midcnt_rst", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(5);
    check_a("midcnt_early", 4'b0000, 1'b0);
    step(1);
    check_a("midcnt_accept", 4'b0001, 1'b1);
    step(1);
    check_a("midcnt_after", 4'b0001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Input-conditioning stage for the four-line sensor bus. Synchronizes each asynchronous raw sensor line into the `clk` domain, debounces it with a per-bit stability counter, and presents a clean registered `sensors[3:0]` vector to the downstream error-detection logic. It also emits a one-cycle `sensors_changed` strobe whenever the clean vector updates.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new level must persist before it is accepted. Legal range is 2..255.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `n_rst`  input  1  reset, asynchronous and active-low. The block has one clock.
- `raw_sensors`  input  4  asynchronous raw sensor lines; bit i is sensor i.
- `sensors`  output  4  debounced, registered sensor vector.
- `sensors_changed`  output  1  registered pulse, high for exactly one cycle when any bit of `sensors` changed at the preceding edge.

## Operation
- **Reset values.** While `n_rst` = 0, every flop clears regardless of `clk`:
  - both synchronizer stages = 0
  - all counters = 0
  - `sensors` = 4'b0000
  - `sensors_changed` = 0
- **Synchronizer.** Per bit: two flops in series, `sync1` <= `raw`, then `sync2` <= `sync1`. There is no logic between the two stages.
- **Debounce.** Per bit, a counter `cnt` of width $clog2(DEBOUNCE_CYCLES) runs against the accepted level `stable` (bit i of `sensors`). At each edge:
  - If `sync2` == `stable`: `cnt` <= 0.
  - Else if `cnt` == DEBOUNCE_CYCLES-1: `stable` <= `sync2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
- **Glitch rejection.** A level at `sync2` that reverts before being accepted clears `cnt`, and `stable` is untouched. There is no partial credit and no hysteresis carry-over.
- **Independence.** Bits are debounced independently. Simultaneous changes on several bits that are accepted on the same edge produce a single `sensors_changed` pulse.
- **Change strobe.** `sensors_changed` <= OR over bits of the "accept with a differing value" condition. It is therefore high in the same cycle the new `sensors` value is first visible. If accepts on different bits occur on consecutive edges, they produce back-to-back pulses.
- **Counter saturation.** `cnt` never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- **Reset mid-operation.** Asserting `n_rst` during a count discards the count and the pending level. After release, a `raw` level of 1 is re-qualified from scratch.

## Timing
- **Latency.** A `raw` level first sampled by `sync1` at edge k and held stable appears on `sensors` after edge k+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges including edge k; 6 edges at the default.
- **Strobe timing.** `sensors_changed` is high during the cycle after edge k+DEBOUNCE_CYCLES+1 and low after the next edge.
- **Minimum accepted pulse.** A `raw` pulse is accepted if it spans at least DEBOUNCE_CYCLES sampling edges at `sync2`. A shorter pulse never reaches `sensors`.
- **Outputs.** All outputs are driven directly from flops, with no combinational path from `raw_sensors`.
- **Reset release.** Recovery from `n_rst` release needs no special handling. The first post-release edge behaves as a normal edge.

## Structure
- **Shared package `sensor_pkg`:**
  - `N_SENSORS` = 4
  - `SENSOR_DEBOUNCE_DEFAULT` = 4
  - typedef `sensor_vec_t` = logic [N_SENSORS-1:0], used on the ports here and by the downstream detector.
- **Sub-module `sensor_debounce_bit`** (ports `clk`, `n_rst`, `raw_in`, `stable_out`, `accept_pulse`; parameter DEBOUNCE_CYCLES). It holds the 2-flop synchronizer, the counter and the stable flop for one line.
- **Top level:**
  - generate-instantiates `sensor_debounce_bit` N_SENSORS times
  - ORs the `accept_pulse` signals into the `sensors_changed` register.

## Test plan
- **Reset:** drive `raw_sensors`=4'b1111 with `n_rst`=0 for 3 edges -> `sensors`=0000 and `sensors_changed`=0 throughout. Drop `n_rst` asynchronously between edges -> outputs clear immediately.
- **Clean step:** `raw_sensors` 0000->0101, held -> `sensors`=0101 after exactly 6 edges. `sensors_changed`=1 for exactly that one cycle.
- **Glitch:** `raw_sensors[1]` high for 3 edges, then low -> `sensors` stays 0000 and no strobe. Repeat with 4 edges -> accepted; then after release, returns to 0 with a second strobe.
- **Simultaneous and staggered bits:**
  - bits 0 and 3 rise on the same edge -> one strobe, `sensors`=1001
  - bit 2 rises one edge later -> two consecutive strobe cycles
- **Reset mid-count:** bit 0 rises and `n_rst` pulses low after 3 edges. `raw` is still 1 after release -> `sensors[0]` reasserts only 6 edges after release.
- **Parameter:** DEBOUNCE_CYCLES=2 -> a step is accepted after 4 edges, and a 1-edge glitch is rejected.
